// File: rtl/bec_la_core.sv
// GF(2^163) bit-serial multiplier driven over Caravel logic-analyzer probes.
// Operands are loaded word by word, the product is read back by word index, and state appears as a status code on GPIO.
module bec_la_core #(
    parameter int M  = 163,
    parameter int NW = 6
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    output logic [127:0] la_data_out,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb
);

    localparam logic [M-1:0] RED = {{(M-8){1'b0}}, 8'hC9};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOADED, S_WERR, S_PROC, S_DONE, S_FINISH
    } state_t;

    state_t          r_state, w_state_next;
    logic            r_wr_prev, r_start_prev, r_ack_prev;
    logic            r_start_pend;
    logic [7:0]      r_test_id;
    logic [M-1:0]    r_a, r_b, r_c;
    logic [M-1:0]    w_a_next, w_b_next, w_c_shift, w_c_step;
    logic [7:0]      r_cnt;
    logic [NW-1:0]   r_mask_a, r_mask_b;
    logic [NW-1:0]   w_mask_a_next, w_mask_b_next, w_idx_bit;

    logic [31:0]     w_wdata;
    logic [2:0]      w_idx;
    logic [1:0]      w_tgt;
    logic            w_wr_edge, w_start_edge, w_ack_edge;
    logic            w_wr_state, w_wr_legal, w_wr_ok, w_wr_bad;
    logic            w_start_ok, w_go, w_all;
    logic [NW*32-1:0] w_c_wide;
    logic [31:0]     w_rword;
    logic [15:0]     w_status;
    logic            w_unused;

    assign w_wdata = la_data_in[31:0];
    assign w_idx   = la_data_in[34:32];
    assign w_tgt   = la_data_in[36:35];

    assign w_wr_edge    = la_data_in[40] & ~r_wr_prev;
    assign w_start_edge = la_data_in[41] & ~r_start_prev;
    assign w_ack_edge   = la_data_in[42] & ~r_ack_prev;

    assign w_wr_state = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                        (r_state == S_LOADED) || (r_state == S_FINISH);
    assign w_wr_legal = (w_idx < 3'(NW)) && !w_tgt[1];
    assign w_wr_ok    = w_wr_edge & w_wr_state & w_wr_legal;
    assign w_wr_bad   = w_wr_edge & w_wr_state & ~w_wr_legal;

    // Start takes effect one cycle after its edge; a write on either cycle cancels it.
    assign w_start_ok = w_start_edge & ~w_wr_edge &
                        ((r_state == S_LOADED) || (r_state == S_DONE));
    assign w_go       = r_start_pend & ~w_wr_edge &
                        ((r_state == S_LOADED) || (r_state == S_DONE));

    assign w_idx_bit     = {{(NW-1){1'b0}}, 1'b1} << w_idx;
    assign w_mask_a_next = ((r_state == S_FINISH) ? '0 : r_mask_a) |
                           ((w_wr_ok && !w_tgt[0]) ? w_idx_bit : '0);
    assign w_mask_b_next = ((r_state == S_FINISH) ? '0 : r_mask_b) |
                           ((w_wr_ok && w_tgt[0]) ? w_idx_bit : '0);
    assign w_all         = (&w_mask_a_next) & (&w_mask_b_next);

    // Only bits below M exist in the operand registers, so higher written bits drop out here.
    always_comb begin
        w_a_next = r_a;
        w_b_next = r_b;
        for (int j = 0; j < M; j++) begin
            if (w_wr_ok && ((j / 32) == int'(w_idx))) begin
                if (w_tgt[0]) w_b_next[j] = w_wdata[j % 32];
                else          w_a_next[j] = w_wdata[j % 32];
            end
        end
    end

    assign w_c_shift = {r_c[M-2:0], 1'b0} ^ (r_c[M-1] ? RED : '0);
    assign w_c_step  = w_c_shift ^ (r_b[r_cnt] ? r_a : '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_LOAD, S_LOADED, S_FINISH: begin
                if (w_wr_bad)     w_state_next = S_WERR;
                else if (w_wr_ok) w_state_next = w_all ? S_LOADED : S_LOAD;
                else if (w_go)    w_state_next = S_PROC;
            end
            S_PROC: if (r_cnt == 8'd0) w_state_next = S_DONE;
            S_DONE: begin
                if (w_go)            w_state_next = S_PROC;
                else if (w_ack_edge) w_state_next = S_FINISH;
            end
            S_WERR:  w_state_next = S_WERR;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_prev    <= 1'b0;
            r_start_prev <= 1'b0;
            r_ack_prev   <= 1'b0;
            r_start_pend <= 1'b0;
            r_test_id    <= 8'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_cnt        <= 8'd0;
            r_mask_a     <= '0;
            r_mask_b     <= '0;
        end else begin
            r_wr_prev    <= la_data_in[40];
            r_start_prev <= la_data_in[41];
            r_ack_prev   <= la_data_in[42];
            r_start_pend <= w_start_ok;
            r_test_id    <= la_data_in[55:48];
            r_a          <= w_a_next;
            r_b          <= w_b_next;
            if (w_wr_ok) begin
                r_mask_a <= w_mask_a_next;
                r_mask_b <= w_mask_b_next;
            end
            if (w_go) begin
                r_c   <= '0;
                r_cnt <= 8'(M-1);
            end else if (r_state == S_PROC) begin
                r_c   <= w_c_step;
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        case (r_state)
            S_IDLE:   w_status = 16'hAB30;
            S_LOAD:   w_status = 16'hAB41;
            S_LOADED: w_status = 16'hAB43;
            S_WERR:   w_status = 16'hAB44;
            S_PROC:   w_status = 16'hAB42;
            S_DONE:   w_status = 16'hAB51;
            S_FINISH: w_status = 16'hABFF;
            default:  w_status = 16'hAB30;
        endcase
    end

    assign w_c_wide = {{(NW*32-M){1'b0}}, r_c};
    assign w_rword  = (w_idx < 3'(NW)) ? w_c_wide[{w_idx, 5'd0} +: 32] : 32'd0;

    assign la_data_out = {{(128-35-NW){1'b0}}, r_mask_a & r_mask_b,
                          r_state == S_WERR, r_state == S_DONE, r_state == S_PROC, w_rword};
    assign io_out      = {6'd0, w_status, r_test_id, 8'd0};
    assign io_oeb      = {6'h3F, 24'd0, 8'hFF};

    assign w_unused = ^{la_data_in[127:56], la_data_in[47:43], la_data_in[39:37]};

endmodule

// File: tb/tb_bec_la_core.sv
// Directed bench for bec_la_core: table of GF(2^163) products with hand-computed results,
// plus sequences for load/error/ack/reset corner cases.
module tb_bec_la_core;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic [127:0] la_in    = '0;
    logic [127:0] la_data_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [191:0] a;
        logic [191:0] b;
        logic [191:0] c;
    } vec_t;

    vec_t vecs [7];

    bec_la_core dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .la_data_in (la_in),
        .la_data_out(la_data_out),
        .io_out     (io_out),
        .io_oeb     (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] wd(input int k, input logic [31:0] v);
        logic [191:0] r;
        r = '0;
        r[k*32 +: 32] = v;
        return r;
    endfunction

    task automatic do_reset();
        la_in[42:40] = 3'b000;
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
    endtask

    task automatic drive_write(input logic [1:0] tgt, input logic [2:0] idx,
                               input logic [31:0] data, input logic with_start);
        la_in[31:0]  = data;
        la_in[34:32] = idx;
        la_in[36:35] = tgt;
        la_in[40]    = 1'b1;
        la_in[41]    = with_start;
        tick();
        la_in[40] = 1'b0;
        la_in[41] = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        la_in[41] = 1'b1;
        tick();
        la_in[41] = 1'b0;
    endtask

    task automatic pulse_ack();
        la_in[42] = 1'b1;
        tick();
        la_in[42] = 1'b0;
    endtask

    task automatic read_word(input int k, output logic [31:0] v);
        la_in[34:32] = 3'(k);
        #1;
        v = la_data_out[31:0];
    endtask

    // Start edge already applied; count cycles until done rises.
    task automatic wait_done(input string name);
        int cycles;
        cycles = 0;
        do begin
            tick();
            cycles++;
            if (cycles == 1) check({name, "_proc_status"}, io_out[31:16], 16'hAB42);
        end while (!la_data_out[33] && cycles < 300);
        check({name, "_latency"}, cycles, 164);
        check({name, "_done_status"}, io_out[31:16], 16'hAB51);
    endtask

    task automatic load_vec(input vec_t v, input string name);
        for (int k = 0; k < 6; k++) begin
            drive_write(2'd0, 3'(k), v.a[k*32 +: 32], 1'b0);
            drive_write(2'd1, 3'(k), v.b[k*32 +: 32], 1'b0);
            if (k == 0) begin
                check({name, "_load_status"}, io_out[31:16], 16'hAB41);
                check({name, "_load_mask"}, la_data_out[40:35], 6'h01);
            end
        end
        check({name, "_loaded_status"}, io_out[31:16], 16'hAB43);
        check({name, "_loaded_mask"}, la_data_out[40:35], 6'h3F);
    endtask

    task automatic check_result(input vec_t v, input string name);
        logic [31:0] w;
        for (int k = 0; k < 6; k++) begin
            read_word(k, w);
            check($sformatf("%s_word%0d", name, k), w, v.c[k*32 +: 32]);
        end
    endtask

    initial begin
        logic [31:0] w;

        vecs[0] = '{a: wd(0, 32'h1), b: wd(0, 32'h2), c: wd(0, 32'h2)};
        vecs[1] = '{a: wd(5, 32'h4), b: wd(0, 32'h2), c: wd(0, 32'hC9)};
        vecs[2] = '{a: wd(3, 32'h10), b: wd(1, 32'h0004_0000), c: wd(4, 32'h0040_0000)};
        vecs[3] = '{a: wd(5, 32'h4), b: wd(5, 32'h4), c: wd(0, 32'h1422) | wd(5, 32'h2)};
        vecs[4] = '{a: wd(5, 32'hFFFF_FFFC), b: wd(0, 32'h2), c: wd(0, 32'hC9)};
        vecs[5] = '{a: wd(0, 32'hFFFF_FFFF) | wd(1, 32'h1234_5678), b: wd(0, 32'h1),
                    c: wd(0, 32'hFFFF_FFFF) | wd(1, 32'h1234_5678)};
        vecs[6] = '{a: wd(0, 32'h3), b: wd(0, 32'h3), c: wd(0, 32'h5)};

        do_reset();
        check("rst_status", io_out[31:16], 16'hAB30);
        check("rst_la_out", la_data_out, 128'd0);
        check("rst_io_out", io_out, {6'd0, 16'hAB30, 16'd0});
        check("rst_io_oeb", io_oeb, 38'h3F_0000_00FF);

        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("idle_start_ignored", io_out[31:16], 16'hAB30);

        la_in[55:48] = 8'h5A;
        tick();
        check("test_id", io_out[15:8], 8'h5A);

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            load_vec(vecs[i], nm);
            pulse_start();
            wait_done(nm);
            check_result(vecs[i], nm);
            if (i == 3) begin
                pulse_start();
                wait_done("restart");
                check_result(vecs[i], "restart");
            end
            pulse_ack();
            check({nm, "_finish_status"}, io_out[31:16], 16'hABFF);
        end

        // Write coinciding with start in LOADED: write lands, start is dropped.
        load_vec(vecs[0], "ws");
        drive_write(2'd0, 3'd0, 32'h1, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("ws_status", io_out[31:16], 16'hAB43);
        check("ws_busy", la_data_out[32], 1'b0);

        pulse_start();
        for (int i = 0; i < 50; i++) tick();
        check("midproc_busy", la_data_out[32], 1'b1);
        do_reset();
        check("midproc_rst_status", io_out[31:16], 16'hAB30);
        check("midproc_rst_busy", la_data_out[32], 1'b0);
        check("midproc_rst_done", la_data_out[33], 1'b0);
        read_word(0, w);
        check("midproc_rst_word0", w, 32'd0);

        load_vec(vecs[0], "werr");
        drive_write(2'd0, 3'd6, 32'hFFFF_FFFF, 1'b0);
        check("werr_idx_status", io_out[31:16], 16'hAB44);
        check("werr_idx_flag", la_data_out[34], 1'b1);
        check("werr_idx_mask", la_data_out[40:35], 6'h3F);
        pulse_start();
        for (int i = 0; i < 170; i++) tick();
        check("werr_start_status", io_out[31:16], 16'hAB44);
        check("werr_start_busy", la_data_out[32], 1'b0);
        check("werr_start_done", la_data_out[33], 1'b0);
        read_word(0, w);
        check("werr_result", w, 32'd0);

        do_reset();
        check("werr_rst_flag", la_data_out[34], 1'b0);
        drive_write(2'd2, 3'd0, 32'h1, 1'b0);
        check("werr_tgt_status", io_out[31:16], 16'hAB44);
        check("werr_tgt_mask", la_data_out[40:35], 6'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
